spi_slave_byte: RTL

- Byte-level SPI slave front end, directly upstream of the command/echo/memory state machine in top.
- Oversamples the external mselect/mclk/mosi pins in the clk domain.
- Deserializes MOSI into bytes with a one-cycle valid strobe.
- Serializes a byte supplied by the command processor onto MISO. Also reports frame start and frame end.

---
 rtl/spi_slave_byte.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/spi_slave_byte.sv
// Byte-level SPI slave: pin oversampling, MOSI deserializer, MISO serializer, frame strobes.
// Define SPI_SLAVE_MODE_EN to add cpol/cpha inputs; otherwise fixed SPI mode 0.
module spi_slave_byte #(
    parameter int SYNC_STAGES = 2,
    parameter int BITS        = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mselect,
    input  logic            mclk,
    input  logic            mosi,
`ifdef SPI_SLAVE_MODE_EN
    input  logic            cpol,
    input  logic            cpha,
`endif
    output logic            miso,
    output logic [BITS-1:0] rx_data,
    output logic            rx_valid,
    input  logic [BITS-1:0] tx_data,
    output logic            tx_ack,
    output logic            active,
    output logic            frame_start,
    output logic            frame_end
);

    localparam int            CW   = (BITS > 1) ? $clog2(BITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BITS - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sel_sync, clk_sync, mosi_sync;
    logic                   mclk_d;
    logic                   sel_s, mclk_s, mosi_s, rise, fall;
    logic                   mclk_rst, sample_edge, shift_edge, load_at_sel;
    logic [CW-1:0]          bit_cnt_q, bit_cnt_d, cnt;
    logic [BITS-2:0]        rx_shift_q, rx_shift_d;
    logic [BITS-1:0]        tx_shift_q, tx_shift_d, word, rx_data_d;
    logic                   rx_valid_d, tx_ack_d, frame_start_d, frame_end_d, in_frame;

    assign sel_s  = sel_sync[SYNC_STAGES-1];
    assign mclk_s = clk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign rise   = mclk_s & ~mclk_d;
    assign fall   = ~mclk_s & mclk_d;

`ifdef SPI_SLAVE_MODE_EN
    logic cpol_q, cpha_q, lead, trail;

    // Mode only changes between frames so a live frame never sees it switch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpol_q <= cpol;
            cpha_q <= cpha;
        end else if (state_q == IDLE) begin
            cpol_q <= cpol;
            cpha_q <= cpha;
        end
    end

    assign mclk_rst    = cpol;
    assign lead        = cpol_q ? fall : rise;
    assign trail       = cpol_q ? rise : fall;
    assign sample_edge = cpha_q ? trail : lead;
    assign shift_edge  = cpha_q ? lead : trail;
    assign load_at_sel = ~cpha_q;
`else
    assign mclk_rst    = 1'b0;
    assign sample_edge = rise;
    assign shift_edge  = fall;
    assign load_at_sel = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_sync  <= '1;
            clk_sync  <= {SYNC_STAGES{mclk_rst}};
            mosi_sync <= '0;
            mclk_d    <= mclk_rst;
        end else begin
            sel_sync  <= {sel_sync[SYNC_STAGES-2:0], mselect};
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], mclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            mclk_d    <= mclk_s;
        end
    end

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        rx_shift_d    = rx_shift_q;
        tx_shift_d    = tx_shift_q;
        rx_data_d     = rx_data;
        rx_valid_d    = 1'b0;
        tx_ack_d      = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        in_frame      = 1'b0;
        cnt           = bit_cnt_q;
        word          = {rx_shift_q, mosi_s};

        // Select is resolved first so an edge in the same cycle lands in the new state.
        case (state_q)
            IDLE: if (!sel_s) begin
                state_d       = SHIFT;
                frame_start_d = 1'b1;
                in_frame      = 1'b1;
                cnt           = '0;
                bit_cnt_d     = '0;
                tx_shift_d    = tx_data;
                tx_ack_d      = load_at_sel;
            end
            SHIFT: if (sel_s) begin
                state_d     = IDLE;
                frame_end_d = 1'b1;
                bit_cnt_d   = '0;
            end else begin
                in_frame = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // A word completed on the deselect cycle is still delivered.
        if (sample_edge && (in_frame || state_q == SHIFT) && cnt == LAST) begin
            rx_data_d  = word;
            rx_valid_d = 1'b1;
        end
        if (sample_edge && in_frame) begin
            rx_shift_d = word[BITS-2:0];
            bit_cnt_d  = (cnt == LAST) ? '0 : cnt + 1'b1;
        end
        if (shift_edge && in_frame) begin
            if (cnt == '0) begin
                tx_shift_d = tx_data;
                tx_ack_d   = 1'b1;
            end else begin
                tx_shift_d = {tx_shift_q[BITS-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_ack      <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            rx_data     <= rx_data_d;
            rx_valid    <= rx_valid_d;
            tx_ack      <= tx_ack_d;
            frame_start <= frame_start_d;
            frame_end   <= frame_end_d;
        end
    end

    assign active = (state_q == SHIFT);
    assign miso   = active & tx_shift_q[BITS-1];

endmodule
